out_display: RTL

- Consumer side of the 8-bit bus registers: captures a byte presented on DIN when LOADn is asserted and shows it as a decimal number on a 4-digit multiplexed 7-segment display.
- Performs an iterative binary-to-BCD conversion (double-dabble) with optional two's-complement signed interpretation.
- Scans the digits continuously.
- Sits at the output port of the CPU, fed from the shared data bus.

---
 rtl/out_display.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/out_display.sv
// Output-port display: latches a bus byte, converts it to BCD by iterative double-dabble,
// and scans it onto a 4-digit multiplexed 7-segment display (digit 3 carries the sign).
module out_display #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       CLR,
    input  logic [7:0] DIN,
    input  logic       LOADn,
    input  logic       SIGNED,
    output logic       BUSY,
    output logic [6:0] SEG,
    output logic [3:0] DIGIT
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state, state_nx;
    logic [2:0]    cnt;
    logic [7:0]    bin;
    logic [11:0]   bcd;
    logic          neg_c;
    logic          pend_v;
    logic [7:0]    pend_din;
    logic          pend_sgn;
    logic [3:0]    hund, tens, ones;
    logic          neg_d;
    logic [PW-1:0] presc;
    logic [1:0]    idx;

    logic          last_iter, load_go, ld_sgn;
    logic [7:0]    ld_din, mag;
    logic [11:0]   bcd_adj;
    logic [19:0]   shifted;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h00;
        endcase
    endfunction

    // A conversion starts from a fresh LOADn when idle, otherwise from the pending slot
    always_comb begin
        last_iter = (state == CONV) && (cnt == 3'd7);
        load_go   = ((state == IDLE) && (!LOADn || pend_v)) || (last_iter && pend_v);
        ld_din    = ((state == IDLE) && !LOADn) ? DIN : pend_din;
        ld_sgn    = ((state == IDLE) && !LOADn) ? SIGNED : pend_sgn;
        mag       = (ld_sgn && ld_din[7]) ? (~ld_din + 8'd1) : ld_din;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin} << 1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!LOADn || pend_v) state_nx = CONV;
            CONV:    if (last_iter && !pend_v) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn || CLR) state <= IDLE;
        else                state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn || CLR) begin
            cnt      <= '0;
            bin      <= '0;
            bcd      <= '0;
            neg_c    <= 1'b0;
            pend_v   <= 1'b0;
            pend_din <= '0;
            pend_sgn <= 1'b0;
            hund     <= '0;
            tens     <= '0;
            ones     <= '0;
            neg_d    <= 1'b0;
        end else begin
            if (load_go) begin
                bin   <= mag;
                bcd   <= '0;
                neg_c <= ld_sgn && ld_din[7];
                cnt   <= '0;
            end else if (state == CONV) begin
                bin <= shifted[7:0];
                bcd <= shifted[19:8];
                cnt <= cnt + 3'd1;
            end
            // Display registers change only here, so partial BCD never reaches SEG
            if (last_iter) begin
                hund  <= shifted[19:16];
                tens  <= shifted[15:12];
                ones  <= shifted[11:8];
                neg_d <= neg_c;
            end
            if ((state == CONV) && !LOADn) begin
                pend_v   <= 1'b1;
                pend_din <= DIN;
                pend_sgn <= SIGNED;
            end else if (load_go) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        BUSY  = (state == CONV);
        DIGIT = 4'b0001 << idx;
        SEG   = 7'h00;
        case (idx)
            2'd0: SEG = dec7(ones);
            2'd1: SEG = ((hund == 4'd0) && (tens == 4'd0)) ? 7'h00 : dec7(tens);
            2'd2: SEG = (hund == 4'd0) ? 7'h00 : dec7(hund);
            2'd3: SEG = neg_d ? 7'h40 : 7'h00;
            default: SEG = 7'h00;
        endcase
    end

endmodule
